// File: rtl/mux_nto1_reg_if.sv
// Handshake bundle for the registered N-to-1 operand mux: per-channel inputs with
// valid/ready, mode/select controls, and a single buffered output word.
interface mux_nto1_reg_if #(
  parameter int WIDTH = 4,
  parameter int NCH   = 4
);
  localparam int SELW = (NCH > 1) ? $clog2(NCH) : 1;

  logic [NCH*WIDTH-1:0] data_in;
  logic [NCH-1:0]       in_valid;
  logic [NCH-1:0]       in_ready;
  logic                 mode;
  logic [SELW-1:0]      sel;
  logic [WIDTH-1:0]     out_data;
  logic [SELW-1:0]      out_ch;
  logic                 out_valid;
  logic                 out_ready;

  modport master (
    output data_in, in_valid, mode, sel, out_ready,
    input  in_ready, out_data, out_ch, out_valid
  );

  modport slave (
    input  data_in, in_valid, mode, sel, out_ready,
    output in_ready, out_data, out_ch, out_valid
  );
endinterface

// File: rtl/mux_nto1_reg.sv
// Registered N-to-1 operand mux with fixed-select and round-robin modes.
// One output word buffer; reloads in the same cycle it drains.
module mux_nto1_reg #(
  parameter int WIDTH = 4,
  parameter int NCH   = 4
) (
  input logic          clk,
  input logic          rst,
  mux_nto1_reg_if.slave bus
);
  localparam int SELW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [SELW:0] NCH_W = (SELW+1)'(NCH);

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SELW-1:0]  out_ch_q, out_ch_d;
  logic             out_valid_q, out_valid_d;
  logic [SELW-1:0]  ptr_q, ptr_d;

  logic             load_en;
  logic             any_valid;
  logic             sel_ok;
  logic             xfer;
  logic [NCH-1:0]   rot;
  logic [NCH-1:0]   ready;
  logic [SELW-1:0]  grant;
  logic [SELW-1:0]  chosen;
  logic [WIDTH-1:0] word;
  int unsigned      g;
  int unsigned      g_next;

  always_comb begin
    load_en   = !out_valid_q || bus.out_ready;

    // rot[k] is the valid of channel (ptr+k) mod NCH, so the first set bit is the grant
    rot       = NCH'({bus.in_valid, bus.in_valid} >> ptr_q);
    any_valid = 1'b0;
    grant     = '0;
    g         = 0;
    for (int unsigned k = 0; k < NCH; k++) begin
      if (!any_valid && rot[k]) begin
        any_valid = 1'b1;
        g         = 32'(ptr_q) + k;
        if (g >= NCH) g = g - NCH;
        grant     = SELW'(g);
      end
    end
    g_next = 32'(grant) + 1;
    if (g_next >= NCH) g_next = 0;

    sel_ok = bus.mode ? any_valid : ({1'b0, bus.sel} < NCH_W);
    chosen = bus.mode ? grant : bus.sel;

    ready = '0;
    word  = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (sel_ok && chosen == SELW'(i)) begin
        ready[i] = load_en;
        word     = bus.data_in[i*WIDTH +: WIDTH];
      end
    end
    xfer = |(ready & bus.in_valid);

    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_valid_d = out_valid_q;
    ptr_d       = ptr_q;
    if (xfer) begin
      out_data_d  = word;
      out_ch_d    = chosen;
      out_valid_d = 1'b1;
      if (bus.mode) ptr_d = SELW'(g_next);
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
      ptr_q       <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
      ptr_q       <= ptr_d;
    end
  end

  assign bus.in_ready  = ready;
  assign bus.out_data  = out_data_q;
  assign bus.out_ch    = out_ch_q;
  assign bus.out_valid = out_valid_q;
endmodule
